// File: rtl/debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_pkg : shared constants and width helpers for the debouncer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package debounce_pkg;

  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_LONG_TICKS   = 64;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // One extra bit so the counter can hold its terminal value without wrapping
  function automatic int cnt_width(input int stable_ticks);
    return clog2(stable_ticks) + 1;
  endfunction

  function automatic int hold_width(input int long_ticks);
    return clog2(long_ticks) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_channel : sync + stability filter + long-press for one button|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int   LONG_TICKS   = DEF_LONG_TICKS,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk_en,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_rise,
  output logic pb_fall,
  output logic pb_long
);

  localparam int CNT_W  = cnt_width(STABLE_TICKS);
  localparam int HOLD_W = hold_width(LONG_TICKS);

  localparam logic [CNT_W-1:0]  C_STAB_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic [CNT_W-1:0]  r_stab_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_done;
  logic              r_rise;
  logic              r_fall;
  logic              r_long;

  logic w_mismatch;
  logic w_flip;
  logic w_hold_fire;

  assign w_mismatch  = (r_sync2 != r_level);
  assign w_flip      = w_mismatch && slow_clk_en && (r_stab_cnt == C_STAB_LAST);
  assign w_hold_fire = r_level && slow_clk_en && !r_long_done && (r_hold_cnt == C_HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= pb_in;
      r_sync2 <= r_sync1;
    end
  end

  // Pulses are registered at the same edge as the level flip, so they
  // coincide with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level    <= IDLE_LEVEL;
      r_stab_cnt <= '0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_rise <= w_flip & r_sync2;
      r_fall <= w_flip & ~r_sync2;
      if (!w_mismatch) begin
        r_stab_cnt <= '0;
      end else if (slow_clk_en) begin
        if (w_flip) begin
          r_level    <= r_sync2;
          r_stab_cnt <= '0;
        end else begin
          r_stab_cnt <= r_stab_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Once long_done is set the counter stops at LONG_TICKS until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_long <= w_hold_fire;
      if (!r_level) begin
        r_hold_cnt  <= '0;
        r_long_done <= 1'b0;
      end else if (slow_clk_en && !r_long_done) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        if (w_hold_fire) begin
          r_long_done <= 1'b1;
        end
      end
    end
  end

  assign pb_level = r_level;
  assign pb_rise  = r_rise;
  assign pb_fall  = r_fall;
  assign pb_long  = r_long;

endmodule
`default_nettype wire

// File: rtl/debounce_multi_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce_multi_channel : N independent push-button conditioners       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module debounce_multi_channel
  import debounce_pkg::*;
#(
  parameter int   N_CH         = 4,
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int   LONG_TICKS   = DEF_LONG_TICKS,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            slow_clk_en,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_rise,
  output logic [N_CH-1:0] pb_fall,
  output logic [N_CH-1:0] pb_long
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .IDLE_LEVEL   (IDLE_LEVEL)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .slow_clk_en (slow_clk_en),
      .pb_in       (pb_in[i]),
      .pb_level    (pb_level[i]),
      .pb_rise     (pb_rise[i]),
      .pb_fall     (pb_fall[i]),
      .pb_long     (pb_long[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_debounce_multi_channel : directed + random bench with ref model    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_debounce_multi_channel;

  logic       clk;
  logic       rst_n;
  logic       en0;
  logic [3:0] pb0, pb1;
  logic [3:0] lvl0, rise0, fall0, long0;
  logic [3:0] lvl1, rise1, fall1, long1;

  int vecs = 0;
  int errs = 0;

  debounce_multi_channel #(.N_CH(4), .STABLE_TICKS(4), .LONG_TICKS(64), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_en(en0), .pb_in(pb0),
    .pb_level(lvl0), .pb_rise(rise0), .pb_fall(fall0), .pb_long(long0)
  );

  debounce_multi_channel #(.N_CH(4), .STABLE_TICKS(1), .LONG_TICKS(3), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .slow_clk_en(1'b1), .pb_in(pb1),
    .pb_level(lvl1), .pb_rise(rise1), .pb_fall(fall1), .pb_long(long1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts qualifying ticks of disagreement and ticks held
  typedef struct {
    int s1; int s2; int lvl; int run; int held; int fired;
    int rise; int fall; int lng;
  } ch_m_t;

  ch_m_t m0[4];
  ch_m_t m1[4];

  function automatic ch_m_t m_reset();
    ch_m_t n;
    n.s1 = 0; n.s2 = 0; n.lvl = 0; n.run = 0; n.held = 0; n.fired = 0;
    n.rise = 0; n.fall = 0; n.lng = 0;
    return n;
  endfunction

  function automatic ch_m_t m_step(ch_m_t m, logic inb, logic en, int st, int lt);
    ch_m_t n;
    n = m;
    n.s1 = inb ? 1 : 0;
    n.s2 = m.s1;
    n.rise = 0; n.fall = 0; n.lng = 0;
    if (m.s2 == m.lvl) n.run = 0;
    else if (en) begin
      n.run = m.run + 1;
      if (n.run >= st) begin
        n.lvl = m.s2; n.run = 0;
        n.rise = m.s2; n.fall = 1 - m.s2;
      end
    end
    if (m.lvl == 0) begin
      n.held = 0; n.fired = 0;
    end else if (en && m.fired == 0) begin
      n.held = m.held + 1;
      if (n.held == lt) begin n.lng = 1; n.fired = 1; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 4; c++) begin
      if (!rst_n) begin
        m0[c] <= m_reset();
        m1[c] <= m_reset();
      end else begin
        m0[c] <= m_step(m0[c], pb0[c], en0, 4, 64);
        m1[c] <= m_step(m1[c], pb1[c], 1'b1, 1, 3);
      end
    end
  end

  int rc[4], fc[4], lc[4];
  int cyc_n, tphase, counting, ticks, long_ticks, rise0_cyc, fall3_cyc;
  bit rand_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 4; c++) begin rc[c] = 0; fc[c] = 0; lc[c] = 0; end
  endtask

  task automatic cyc();
    logic [3:0] el0, er0, ef0, eg0, el1, er1, ef1, eg1;
    @(negedge clk);
    cyc_n++;
    for (int c = 0; c < 4; c++) begin
      el0[c] = (m0[c].lvl != 0);  er0[c] = (m0[c].rise != 0);
      ef0[c] = (m0[c].fall != 0); eg0[c] = (m0[c].lng != 0);
      el1[c] = (m1[c].lvl != 0);  er1[c] = (m1[c].rise != 0);
      ef1[c] = (m1[c].fall != 0); eg1[c] = (m1[c].lng != 0);
    end
    chk("level0", 32'(lvl0), 32'(el0));
    chk("rise0",  32'(rise0), 32'(er0));
    chk("fall0",  32'(fall0), 32'(ef0));
    chk("long0",  32'(long0), 32'(eg0));
    chk("level1", 32'(lvl1), 32'(el1));
    chk("rise1",  32'(rise1), 32'(er1));
    chk("fall1",  32'(fall1), 32'(ef1));
    chk("long1",  32'(long1), 32'(eg1));
    for (int c = 0; c < 4; c++) begin
      if (rise0[c] === 1'b1) rc[c]++;
      if (fall0[c] === 1'b1) fc[c]++;
      if (long0[c] === 1'b1) lc[c]++;
    end
    // en0 still holds the value sampled at the edge just observed
    if (counting != 0 && en0) ticks++;
    if (rise0[2] === 1'b1) begin counting = 1; ticks = 0; end
    if (long0[2] === 1'b1) long_ticks = ticks;
    if (rise0[0] === 1'b1) rise0_cyc = cyc_n;
    if (fall0[3] === 1'b1) fall3_cyc = cyc_n;
    if (rand_en) en0 = ($urandom_range(0, 7) == 0);
    else begin
      tphase = (tphase + 1) % 10;
      en0 = (tphase == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    int k;
    rst_n = 1'b0; pb0 = 4'h0; pb1 = 4'h0; en0 = 1'b0;
    tphase = 0; rand_en = 1'b0; cyc_n = 0; counting = 0; ticks = 0;
    long_ticks = -1; rise0_cyc = -1; fall3_cyc = -2;
    clr();
    run(3);
    chk("reset_level", 32'(lvl0), 32'h0);
    chk("reset_pulses", 32'(rise0 | fall0 | long0), 32'h0);
    rst_n = 1'b1;

    // Single press on ch0
    clr();
    pb0[0] = 1'b1;
    run(70);
    chk("t1_level", 32'(lvl0), 32'h1);
    chk("t1_rise0", rc[0], 1);
    chk("t1_other_pulses", rc[1] + rc[2] + rc[3] + fc[0] + fc[1] + fc[2] + fc[3], 0);

    // Bounce on ch1: short burst must be rejected
    clr();
    pb0[1] = 1'b1; run(20);
    pb0[1] = 1'b0; run(10);
    pb0[1] = 1'b1; run(70);
    chk("t2_rise1", rc[1], 1);
    chk("t2_fall1", fc[1], 0);
    chk("t2_level1", 32'(lvl0[1]), 32'h1);

    // Long hold on ch2
    clr();
    pb0[2] = 1'b1;
    run(860);
    chk("t3_long_count", lc[2], 1);
    chk("t3_long_ticks", long_ticks, 64);
    chk("t3_rise2", rc[2], 1);
    pb0[2] = 1'b0;
    run(60);
    chk("t3_fall2", fc[2], 1);
    chk("t3_long_after", lc[2], 1);
    counting = 0;

    // Simultaneous press ch0 / release ch3
    pb0[0] = 1'b0; pb0[3] = 1'b1;
    run(60);
    clr();
    rise0_cyc = -1; fall3_cyc = -2;
    pb0[0] = 1'b1; pb0[3] = 1'b0;
    run(60);
    chk("t4_rise0", rc[0], 1);
    chk("t4_fall3", fc[3], 1);
    chk("t4_same_cycle", rise0_cyc, fall3_cyc);

    // Reset mid-hold (ch2) and mid-count (ch3)
    pb0[2] = 1'b1;
    run(400);
    pb0[3] = 1'b1;
    run(25);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_level", 32'(lvl0), 32'h0);
    chk("t5_async_pulses", 32'(rise0 | fall0 | long0), 32'h0);
    chk("t5_async_level1", 32'(lvl1), 32'h0);
    run(3);
    rst_n = 1'b1;
    clr();
    run(400);
    chk("t5_requal_level", 32'(lvl0), 32'hF);
    chk("t5_requal_rises", rc[0] + rc[1] + rc[2] + rc[3], 4);
    chk("t5_no_long", lc[0] + lc[1] + lc[2] + lc[3], 0);

    // STABLE_TICKS=1 with enable tied high: 3 clk latency
    pb1[0] = 1'b1;
    cyc(); chk("t6_lat1", 32'(lvl1[0]), 32'h0);
    cyc(); chk("t6_lat2", 32'(lvl1[0]), 32'h0);
    cyc(); chk("t6_lat3", 32'(lvl1[0]), 32'h1);
    chk("t6_rise", 32'(rise1[0]), 32'h1);
    cyc(); chk("t6_rise_gone", 32'(rise1[0]), 32'h0);
    pb1[0] = 1'b0;
    run(3);
    chk("t6_fall", 32'(fall1[0]), 32'h1);
    cyc(); chk("t6_fall_gone", 32'(fall1[0]), 32'h0);

    // Random bouncing on both instances
    rand_en = 1'b1;
    repeat (2000) begin
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, 3);
        pb0[k] = ~pb0[k];
      end
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 3);
        pb1[k] = ~pb1[k];
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
